// File: rtl/xmtfifo_pkg.sv
// xmt_pkg: shared types and constants for the xmtfifo transmitter.
// Optional parity is selected with the XMTFIFO_PARITY_EN macro.
package xmt_pkg;

  localparam int   BIT_LEN_W = 16;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } ser_state_t;

endpackage

// File: rtl/xmtfifo_xmtser.sv
// xmtser: frame serializer for xmtfifo (start, data LSB first, optional
// parity, one or two stop bits). Parity exists only when XMTFIFO_PARITY_EN
// is defined.
//
// state | meaning
// IDLE  | line high, waiting for a load
// START | driving the start bit (0)
// DATA  | driving data bits, LSB first
// PAR   | driving the parity bit (parity builds only)
// STOP  | driving one or two stop bits (1)
module xmtser
  import xmt_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_W-1:0]    data,
  input  logic [BIT_LEN_W-1:0] bit_len,
  input  logic                 stop2,
  input  logic                 par_odd,
  output logic                 take,
  output logic                 idle,
  output logic                 serial_out
);

  localparam int BCW = $clog2(DATA_W);

  ser_state_t           state;
  logic [BIT_LEN_W-1:0] cnt;
  logic [BIT_LEN_W-1:0] bl_r;
  logic                 stop2_r;
  logic                 stop_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic [DATA_W-1:0]    shift;
  logic                 line;
  logic                 final_stop;

`ifdef XMTFIFO_PARITY_EN
  logic par_r;
`else
  logic unused_par_odd;
  assign unused_par_odd = par_odd;
`endif

  // A new frame may be loaded when idle or on the very last stop-bit clock,
  // which lets frames run back to back with no idle gap.
  assign final_stop = (state == STOP) && (cnt == '0) && (!stop2_r || stop_cnt);
  assign take       = (state == IDLE) || final_stop;
  assign idle       = (state == IDLE);

  // Line level implied by the current state; registered into serial_out.
  always_comb begin
    line = LINE_IDLE;
    case (state)
      START:   line = 1'b0;
      DATA:    line = shift[0];
`ifdef XMTFIFO_PARITY_EN
      PAR:     line = par_r;
`endif
      default: line = LINE_IDLE;
    endcase
  end

  // Serializer FSM: bit-rate down-counter, bit counter and shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bl_r       <= '0;
      stop2_r    <= 1'b0;
      stop_cnt   <= 1'b0;
      bit_cnt    <= '0;
      shift      <= '0;
      serial_out <= LINE_IDLE;
`ifdef XMTFIFO_PARITY_EN
      par_r      <= 1'b0;
`endif
    end else begin
      serial_out <= line;
      if (load) begin
        state   <= START;
        cnt     <= bit_len - 1'b1;
        bl_r    <= bit_len;
        stop2_r <= stop2;
        shift   <= data;
`ifdef XMTFIFO_PARITY_EN
        par_r   <= (^data) ^ par_odd;
`endif
      end else if (state != IDLE) begin
        if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end else begin
          cnt <= bl_r - 1'b1;
          case (state)
            START: begin
              state   <= DATA;
              bit_cnt <= '0;
            end
            DATA: begin
              shift <= shift >> 1;
              if (bit_cnt == BCW'(DATA_W - 1)) begin
`ifdef XMTFIFO_PARITY_EN
                state <= PAR;
`else
                state <= STOP;
`endif
                stop_cnt <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
            PAR: begin
              state    <= STOP;
              stop_cnt <= 1'b0;
            end
            STOP: begin
              if (stop2_r && !stop_cnt) stop_cnt <= 1'b1;
              else                      state    <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: rtl/xmtfifo.sv
// xmtfifo: serial transmitter with a DEPTH-entry transmit FIFO, sticky
// overflow flag and flush. Parity is enabled by defining XMTFIFO_PARITY_EN.
module xmtfifo
  import xmt_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [BIT_LEN_W-1:0] bit_len,
  input  logic                 stop2,
  input  logic                 par_odd,
  input  logic                 write,
  input  logic [DATA_W-1:0]    data_in,
  input  logic                 flush,
  output logic                 ready,
  output logic                 empty,
  output logic [AW:0]          level,
  output logic                 ovf,
  output logic                 serial_out
);

  localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              push;
  logic              pop;
  logic              take;
  logic              idle;

  assign ready = (level != LVL_FULL);
  assign push  = write && ready && !flush;
  assign pop   = take && (level != '0) && !flush;
  assign empty = idle && (level == '0);

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= data_in;
  end

  // Pointers, occupancy and sticky overflow; flush wins over write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ovf   <= 1'b0;
    end else begin
      if (write && !ready) ovf  <= 1'b1;
      if (push)            wptr <= wptr + 1'b1;
      if (pop)             rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  xmtser #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (pop),
    .data       (mem[rptr]),
    .bit_len    (bit_len),
    .stop2      (stop2),
    .par_odd    (par_odd),
    .take       (take),
    .idle       (idle),
    .serial_out (serial_out)
  );

endmodule

// File: tb/tb_xmtfifo.sv
// Self-checking bench for xmtfifo: a transaction-level FIFO/frame model
// predicts occupancy and line waveforms; a line monitor decodes frames.
module tb_xmtfifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef XMTFIFO_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [15:0]   bit_len;
  logic          stop2, par_odd, write, flush;
  logic [DW-1:0] data_in;
  logic          ready, empty, ovf, serial_out;
  logic [AW:0]   level;

  always #5 clk = ~clk;

  xmtfifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bit_len(bit_len), .stop2(stop2), .par_odd(par_odd),
    .write(write), .data_in(data_in), .flush(flush), .ready(ready),
    .empty(empty), .level(level), .ovf(ovf), .serial_out(serial_out)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [DW-1:0] d;
    int            bl;
    bit            s2;
    bit            po;
  } frm_t;

  // Reference model: queue of stored chars, frames handed to the line,
  // and clocks remaining in the frame currently being sent.
  logic [DW-1:0] mq[$];
  frm_t          lineq[$];
  int            ser_rem;
  bit            m_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      lineq.delete();
      ser_rem = 0;
      m_ovf   = 1'b0;
    end else begin
      bit            pop_ok;
      bit            rdy;
      logic [DW-1:0] head;
      frm_t          f;
      pop_ok = (ser_rem <= 1) && (mq.size() > 0) && !flush;
      rdy    = (mq.size() < DEPTH);
      if (pop_ok) begin
        head = mq.pop_front();
        f.d = head; f.bl = int'(bit_len); f.s2 = stop2; f.po = par_odd;
        lineq.push_back(f);
      end
      if (flush) begin
        mq.delete();
        m_ovf = 1'b0;
      end else if (write) begin
        if (rdy) mq.push_back(data_in);
        else     m_ovf = 1'b1;
      end
      if (pop_ok)           ser_rem = int'(bit_len) * (1 + DW + PB + (stop2 ? 2 : 1));
      else if (ser_rem > 0) ser_rem = ser_rem - 1;
    end
  end

  // Status outputs against the model every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      logic [AW:0] e_lvl;
      bit          e_rdy, e_emp;
      e_lvl = (AW + 1)'(mq.size());
      e_rdy = (mq.size() < DEPTH);
      e_emp = (mq.size() == 0) && (ser_rem == 0);
      tests++;
      if (level !== e_lvl || ready !== e_rdy || ovf !== m_ovf || empty !== e_emp) begin
        fails++;
        $display("FAIL status t=%0t level=%0d/%0d ready=%b/%b ovf=%b/%b empty=%b/%b (got/required)",
                 $time, level, e_lvl, ready, e_rdy, ovf, m_ovf, empty, e_emp);
      end
    end
  end

  // Line monitor: detects start bits and checks every clock of each frame.
  bit          mon_act = 1'b0;
  bit          skip    = 1'b0;
  int          quiet   = 0;
  int          mon_pos, mon_len, mon_bad, mbl;
  logic [15:0] pat;
  logic [DW-1:0] mdat;
  int          frames_done = 0;
  int          gap = 0;
  int          gaps[$];

  always @(negedge clk) begin
    if (rst) begin
      mon_act = 1'b0;
      skip    = 1'b0;
      gap     = 0;
    end else begin
      if (skip) begin
        if (serial_out === 1'b1) quiet++;
        else                     quiet = 0;
        if (quiet >= 40) skip = 1'b0;
      end else if (!mon_act) begin
        if (serial_out !== 1'b1) begin
          if (lineq.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_frame t=%0t line=%b, no frame required", $time, serial_out);
            skip = 1'b1; quiet = 0;
          end else begin
            frm_t f;
            int   nb;
            f    = lineq.pop_front();
            pat  = '1;
            pat[0] = 1'b0;
            for (int i = 0; i < DW; i++) pat[1 + i] = f.d[i];
            if (PB == 1) pat[DW + 1] = (^f.d) ^ f.po;
            nb      = 1 + DW + PB + (f.s2 ? 2 : 1);
            mbl     = f.bl;
            mdat    = f.d;
            mon_len = nb * f.bl;
            mon_pos = 0;
            mon_bad = -1;
            mon_act = 1'b1;
            gaps.push_back(gap);
            gap = 0;
          end
        end else begin
          gap++;
        end
      end
      if (mon_act) begin
        if (serial_out !== pat[mon_pos / mbl] && mon_bad < 0) mon_bad = mon_pos;
        mon_pos++;
        if (mon_pos == mon_len) begin
          mon_act = 1'b0;
          frames_done++;
          tests++;
          if (mon_bad >= 0) begin
            fails++;
            $display("FAIL frame data=%h first wrong clock %0d of %0d (required bit %b)",
                     mdat, mon_bad, mon_len, pat[mon_bad / mbl]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  task automatic step(input bit w, input logic [DW-1:0] d, input bit f);
    @(negedge clk);
    write = w; data_in = d; flush = f;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk); #1;
    write = 1'b0; flush = 1'b0;
    while ((mq.size() != 0 || ser_rem != 0 || mon_act || lineq.size() != 0) && n < 5000) begin
      @(negedge clk); #1;
      n++;
    end
    chk("drain_timeout", int'(n < 5000), 1);
  endtask

  typedef struct {
    bit            w;
    logic [DW-1:0] d;
    int            lvl;
    bit            rdy;
    bit            ov;
  } vec_t;

  vec_t tbl[7];
  int   f0;

  initial begin
    tbl[0] = '{1'b1, 8'h11, 1, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 2, 1'b1, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 3, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 4, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h66, 4, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 8'h00, 4, 1'b0, 1'b1};

    rst = 1'b1; write = 1'b0; flush = 1'b0; data_in = '0;
    bit_len = 16'd4; stop2 = 1'b0; par_odd = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_empty", int'(empty), 1);
    chk("rst_level", int'(level), 0);
    chk("rst_ovf", int'(ovf), 0);
    chk("rst_line", int'(serial_out), 1);
    rst = 1'b0;

    // Basic frame: write 0x55 at edge k, line low from k+2.
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("basic_level_k", int'(level), 1);
    chk("basic_line_k", int'(serial_out), 1);
    step(1'b0, 8'h00, 1'b0);
    chk("basic_level_k1", int'(level), 0);
    chk("basic_line_k1", int'(serial_out), 1);
    step(1'b0, 8'h00, 1'b0);
    chk("basic_line_k2", int'(serial_out), 0);
    repeat (4 * (1 + DW + PB + 1)) @(negedge clk);
    chk("basic_empty_end", int'(empty), 1);
    #1;
    chk("basic_frames", frames_done, 1);

    // Overflow table: slow bit rate, DEPTH+2 consecutive writes.
    bit_len = 16'd20;
    f0 = frames_done;
    @(negedge clk);
    write = tbl[0].w; data_in = tbl[0].d;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("ovf_tbl%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("ovf_tbl%0d_ready", i), int'(ready), int'(tbl[i].rdy));
      chk($sformatf("ovf_tbl%0d_ovf", i), int'(ovf), int'(tbl[i].ov));
      if (i < 6) begin write = tbl[i + 1].w; data_in = tbl[i + 1].d; end
    end
    drain();
    chk("ovf_frames", frames_done - f0, 5);

    // Back-to-back: three writes while busy; bit_len changed mid-frame.
    bit_len = 16'd3;
    gaps.delete();
    step(1'b1, 8'hA1, 1'b0);
    step(1'b1, 8'hB2, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b1, 8'hD4, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    bit_len = 16'd7;
    drain();
    chk("b2b_frames", gaps.size(), 4);
    for (int i = 1; i < 4 && i < gaps.size(); i++) chk($sformatf("b2b_gap%0d", i), gaps[i], 0);

    // Two stop bits and flush mid-frame with level=3.
    bit_len = 16'd3; stop2 = 1'b1;
    f0 = frames_done;
    step(1'b1, 8'h0F, 1'b0);
    step(1'b1, 8'hF0, 1'b0);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b1, 8'hC3, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("flush_pre_level", int'(level), 3);
    chk("flush_pre_ovf", int'(ovf), 1);
    repeat (5) step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h99, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("flush_level", int'(level), 0);
    chk("flush_ovf", int'(ovf), 0);
    repeat (100) @(negedge clk);
    drain();
    chk("flush_frames", frames_done - f0, 1);

    // Parity cases (plain frames without the parity build).
    stop2 = 1'b0; bit_len = 16'd2;
    for (int p = 0; p < 2; p++) begin
      par_odd = p[0];
      step(1'b1, 8'h03, 1'b0);
      step(1'b1, 8'h07, 1'b0);
      drain();
    end
    par_odd = 1'b0;

    // Reset mid-frame during a data bit.
    bit_len = 16'd4;
    f0 = frames_done;
    step(1'b1, 8'hA5, 1'b0);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    repeat (14) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_line", int'(serial_out), 1);
    chk("rstmid_level", int'(level), 0);
    chk("rstmid_empty", int'(empty), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    chk("rstmid_frames", frames_done - f0, 0);
    chk("rstmid_idle_line", int'(serial_out), 1);

    // Randomized traffic against the model.
    f0 = frames_done;
    for (int c = 0; c < 2500; c++) begin
      if (c % 60 == 0) begin
        @(negedge clk);
        bit_len = 16'($urandom_range(2, 5));
        stop2   = 1'($urandom_range(0, 1));
        par_odd = 1'($urandom_range(0, 1));
      end
      step(($urandom % 3) == 0, DW'($urandom), ($urandom % 97) == 0);
    end
    drain();
    chk("rand_some_frames", int'(frames_done - f0 > 20), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
